// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding and constants for the pipeline register slice.
// Revision 1.0 - initial release.
`default_nettype none

package pipe_pkg;

  localparam int STALL_CNT_W = 16;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_TWO   = 2'd2
  } pipe_state_e;

endpackage

`default_nettype wire

// File: rtl/pipe_skid_reg_if.sv
// pipe_skid_reg_if: valid/ready/data handshake bundle with producer/consumer views.
// Revision 1.0 - initial release.
`default_nettype none

interface pipe_skid_reg_if #(
  parameter int DATA_W = 32
);

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

`default_nettype wire

// File: rtl/pipe_sat_counter.sv
// pipe_sat_counter: up-counter that sticks at all-ones; synchronous active-low reset.
// Revision 1.0 - initial release.
`default_nettype none

module pipe_sat_counter #(
  parameter int WIDTH = 16
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             i_inc,
  output logic [WIDTH-1:0]      o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: generic inter-stage register with flush and back-pressure counter.
// Define PIPE_SKID_REG_SKID_EN for the two-entry skid with registered in_ready. Revision 1.0.
`default_nettype none

module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W          = 32,
  parameter bit CLEAR_ON_BUBBLE = 1'b1
) (
  input  wire logic               clk,
  input  wire logic               reset,
  input  wire logic               flush,
  pipe_skid_reg_if.slave          s_in,
  pipe_skid_reg_if.master         m_out,
  output logic [1:0]              occupancy,
  output logic [STALL_CNT_W-1:0]  stall_cnt
);

  pipe_state_e       r_state;
  pipe_state_e       w_next;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] w_main_d;
  logic              w_main_en;
  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_in_fire;
  logic              w_out_fire;

  assign w_out_valid = (r_state != PS_EMPTY);
  assign w_in_fire   = s_in.valid & w_in_ready;
  assign w_out_fire  = w_out_valid & m_out.ready;

`ifdef PIPE_SKID_REG_SKID_EN
  logic [DATA_W-1:0] r_skid;
  logic              r_in_ready;
  logic              w_skid_en;
`endif

  always_comb begin
    w_next    = r_state;
    w_main_en = 1'b0;
    w_main_d  = s_in.data;
`ifdef PIPE_SKID_REG_SKID_EN
    w_skid_en = 1'b0;
`endif
    case (r_state)
      PS_EMPTY: begin
        if (w_in_fire) begin
          w_main_en = 1'b1;
          w_next    = PS_ONE;
        end
      end
      PS_ONE: begin
        if (w_in_fire && w_out_fire) begin
          w_main_en = 1'b1;
`ifdef PIPE_SKID_REG_SKID_EN
        end else if (w_in_fire) begin
          w_skid_en = 1'b1;
          w_next    = PS_TWO;
`endif
        end else if (w_out_fire) begin
          w_next = PS_EMPTY;
        end
      end
`ifdef PIPE_SKID_REG_SKID_EN
      PS_TWO: begin
        // Skid entry is older than anything upstream, so it refills main first.
        if (w_out_fire) begin
          w_main_en = 1'b1;
          w_main_d  = r_skid;
          w_next    = PS_ONE;
        end
      end
`endif
      default: w_next = PS_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= PS_EMPTY;
      r_main  <= '0;
    end else if (flush) begin
      r_state <= PS_EMPTY;
      if (CLEAR_ON_BUBBLE) r_main <= '0;
    end else begin
      r_state <= w_next;
      if (w_main_en) r_main <= w_main_d;
    end
  end

`ifdef PIPE_SKID_REG_SKID_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_skid     <= '0;
      r_in_ready <= 1'b1;
    end else if (flush) begin
      if (CLEAR_ON_BUBBLE) r_skid <= '0;
      r_in_ready <= 1'b1;
    end else begin
      if (w_skid_en) r_skid <= s_in.data;
      r_in_ready <= (w_next != PS_TWO);
    end
  end

  assign w_in_ready = r_in_ready;
`else
  assign w_in_ready = ~w_out_valid | m_out.ready;
`endif

  assign s_in.ready  = w_in_ready;
  assign m_out.valid = w_out_valid;

  generate
    if (CLEAR_ON_BUBBLE) begin : g_clear_bubble
      assign m_out.data = w_out_valid ? r_main : '0;
    end else begin : g_keep_stale
      assign m_out.data = r_main;
    end
  endgenerate

  always_comb begin
    case (r_state)
      PS_ONE:  occupancy = 2'd1;
      PS_TWO:  occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  pipe_sat_counter #(
    .WIDTH (STALL_CNT_W)
  ) u_stall_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (w_out_valid & ~m_out.ready),
    .o_count (stall_cnt)
  );

endmodule

`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: directed self-checking bench for pipe_skid_reg (either skid build).
// Revision 1.0 - initial release.
`default_nettype none

module tb_pipe_skid_reg;
  import pipe_pkg::*;

  logic        clk;
  logic        reset;
  logic        flush;
  logic [1:0]  occupancy;
  logic [15:0] stall_cnt;
  int          n_checks;
  int          n_errors;
  int          exp_stall;

  pipe_skid_reg_if #(.DATA_W(32)) up_if ();
  pipe_skid_reg_if #(.DATA_W(32)) dn_if ();

  pipe_skid_reg #(
    .DATA_W          (32),
    .CLEAR_ON_BUBBLE (1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .s_in      (up_if.slave),
    .m_out     (dn_if.master),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    exp_stall   = 0;
    reset       = 1'b0;
    flush       = 1'b0;
    up_if.valid = 1'b1;
    up_if.data  = 32'hDEADBEEF;
    dn_if.ready = 1'b0;

    // Reset held two cycles with a beat offered upstream.
    tick();
    tick();
    check_eq("rst_out_valid", {31'd0, dn_if.valid}, 32'd0);
    check_eq("rst_out_data", dn_if.data, 32'd0);
    check_eq("rst_stall", {16'd0, stall_cnt}, 32'd0);
    check_eq("rst_occ", {30'd0, occupancy}, 32'd0);
    reset       = 1'b1;
    up_if.valid = 1'b0;
    #1;
    check_eq("rst_in_ready", {31'd0, up_if.ready}, 32'd1);

    // Back-to-back stream with no back-pressure.
    dn_if.ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      up_if.valid = 1'b1;
      up_if.data  = i;
      tick();
      check_eq("stream_valid", {31'd0, dn_if.valid}, 32'd1);
      check_eq("stream_data", dn_if.data, i);
      check_eq("stream_occ", {30'd0, occupancy}, 32'd1);
    end
    up_if.valid = 1'b0;
    tick();
    check_eq("drain_valid", {31'd0, dn_if.valid}, 32'd0);
    check_eq("drain_data", dn_if.data, 32'd0);
    check_eq("drain_stall", {16'd0, stall_cnt}, 32'd0);

`ifdef PIPE_SKID_REG_SKID_EN
    // Back-pressure fills the skid entry.
    dn_if.ready = 1'b0;
    up_if.valid = 1'b1;
    up_if.data  = 32'd5;
    tick();
    up_if.data  = 32'd6;
    tick();
    exp_stall += 1;
    check_eq("bp_occ2", {30'd0, occupancy}, 32'd2);
    check_eq("bp_in_ready", {31'd0, up_if.ready}, 32'd0);
    check_eq("bp_hold5", dn_if.data, 32'd5);
    up_if.valid = 1'b0;
    tick();
    exp_stall += 1;
    check_eq("bp_still5", dn_if.data, 32'd5);
    dn_if.ready = 1'b1;
    tick();
    check_eq("bp_data6", dn_if.data, 32'd6);
    check_eq("bp_occ1", {30'd0, occupancy}, 32'd1);
    check_eq("bp_ready_back", {31'd0, up_if.ready}, 32'd1);
    tick();
    check_eq("bp_occ0", {30'd0, occupancy}, 32'd0);
    check_eq("bp_stall", {16'd0, stall_cnt}, exp_stall);
`else
    // Combinational in_ready follows out_ready in the same cycle.
    dn_if.ready = 1'b0;
    up_if.valid = 1'b1;
    up_if.data  = 32'd10;
    tick();
    up_if.data  = 32'd11;
    #1;
    check_eq("nsk_ready_lo", {31'd0, up_if.ready}, 32'd0);
    check_eq("nsk_hold10", dn_if.data, 32'd10);
    dn_if.ready = 1'b1;
    #1;
    check_eq("nsk_ready_hi", {31'd0, up_if.ready}, 32'd1);
    tick();
    check_eq("nsk_data11", dn_if.data, 32'd11);
    check_eq("nsk_occ", {30'd0, occupancy}, 32'd1);
    up_if.valid = 1'b0;
    tick();
    check_eq("nsk_empty", {31'd0, dn_if.valid}, 32'd0);
    check_eq("nsk_stall", {16'd0, stall_cnt}, exp_stall);
`endif

    // Flush with held entries and a beat offered in the flush cycle.
    dn_if.ready = 1'b0;
    up_if.valid = 1'b1;
    up_if.data  = 32'd7;
    tick();
`ifdef PIPE_SKID_REG_SKID_EN
    up_if.data  = 32'd8;
    tick();
    exp_stall += 1;
    check_eq("fl_occ2", {30'd0, occupancy}, 32'd2);
`else
    check_eq("fl_occ1", {30'd0, occupancy}, 32'd1);
`endif
    flush       = 1'b1;
    up_if.data  = 32'd9;
    tick();
    exp_stall += 1;
    flush       = 1'b0;
    up_if.valid = 1'b0;
    check_eq("fl_valid", {31'd0, dn_if.valid}, 32'd0);
    check_eq("fl_data", dn_if.data, 32'd0);
    check_eq("fl_occ0", {30'd0, occupancy}, 32'd0);
    dn_if.ready = 1'b1;
    tick();
    tick();
    check_eq("fl_no9", {31'd0, dn_if.valid}, 32'd0);
    check_eq("fl_stall", {16'd0, stall_cnt}, exp_stall);

    // Saturation of the back-pressure counter, then flush must not clear it.
    dn_if.ready = 1'b0;
    up_if.valid = 1'b1;
    up_if.data  = 32'd12;
    tick();
    up_if.valid = 1'b0;
    check_eq("sat_hold12", dn_if.data, 32'd12);
    repeat (70000) tick();
    check_eq("sat_ffff", {16'd0, stall_cnt}, 32'h0000FFFF);
    check_eq("sat_data12", dn_if.data, 32'd12);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_eq("sat_after_flush", {16'd0, stall_cnt}, 32'h0000FFFF);
    check_eq("sat_flush_valid", {31'd0, dn_if.valid}, 32'd0);

    // Reset mid-stream overrides a simultaneous flush and handshake.
    up_if.valid = 1'b1;
    up_if.data  = 32'd13;
    tick();
    check_eq("mr_loaded", dn_if.data, 32'd13);
    reset = 1'b0;
    flush = 1'b1;
    tick();
    reset       = 1'b1;
    flush       = 1'b0;
    up_if.valid = 1'b0;
    check_eq("mr_valid", {31'd0, dn_if.valid}, 32'd0);
    check_eq("mr_stall", {16'd0, stall_cnt}, 32'd0);
    check_eq("mr_occ", {30'd0, occupancy}, 32'd0);
    check_eq("mr_in_ready", {31'd0, up_if.ready}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised inter-stage pipeline register for the pipelined CPU datapath, replacing hand-written per-stage registers (fetch/decode, decode/execute, etc.) with one generic block. Carries an opaque DATA_W-bit bundle from one stage to the next under a valid/ready handshake, with synchronous flush (bubble insertion) and an optional two-entry skid buffer that registers the ready path. Also exports occupancy and a saturating back-pressure counter for performance debug.

## Interface
- DATA_W, 32, width of the stage bundle (≥1)
- CLEAR_ON_BUBBLE, 1, when 1 out_data reads all-zero whenever out_valid=0; when 0 stale data is retained
- clk  input  1  clock; all state changes on posedge
- reset  input  1  synchronous, active-low reset (reset=0 sampled at posedge clears block)
- flush  input  1  synchronous kill of all held entries (branch/jump squash)
- in_valid  input  1  upstream beat present
- in_ready  output  1  block can accept a beat
- in_data  input  DATA_W  upstream bundle
- out_valid  output  1  beat presented downstream
- out_ready  input  1  downstream accepts
- out_data  output  DATA_W  downstream bundle
- occupancy  output  2  entries held (0..2; 0..1 without skid)
- stall_cnt  output  16  saturating count of cycles with out_valid=1 and out_ready=0

## Operation
- Fire: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Skid states (PS_EMPTY, PS_ONE, PS_TWO): main register feeds out_data; skid register holds overflow.
- PS_EMPTY: in_fire → main<=in_data, PS_ONE.
- PS_ONE: in_fire & out_fire → main<=in_data, stay; in_fire & !out_fire → skid<=in_data, PS_TWO; !in_fire & out_fire → PS_EMPTY.
- PS_TWO: in_ready=0; out_fire → main<=skid, PS_ONE.
- out_valid = state≠PS_EMPTY; occupancy = 0/1/2 per state.
- Flush: priority below reset, above handshake. State→PS_EMPTY; a beat that fires on in_fire in the flush cycle is discarded; out_fire in that cycle still counts as delivered downstream. With CLEAR_ON_BUBBLE=1, main and skid zeroed.
- stall_cnt: +1 each cycle out_valid & !out_ready; holds at 16'hFFFF; cleared only by reset (not by flush).
- Data never reordered, duplicated or dropped except by flush.

## Timing
- Reset (reset=0 at posedge): state PS_EMPTY, out_valid=0, in_ready=1 from next cycle, out_data=0, occupancy=0, stall_cnt=0.
- Latency in_fire → out_valid: 1 cycle. Throughput 1 beat/cycle sustained when out_ready=1.
- in_ready with skid: pure register output (no combinational path from out_ready); deasserts the cycle after entering PS_TWO.
- out_valid/out_data never depend combinationally on in_* .
- out_ready deasserted with out_valid=1: out_data stable until out_fire or flush.
- Reset mid-stream overrides flush and all handshakes.

## Configuration
- PIPE_SKID_REG_SKID_EN defined: two-entry skid as above, registered in_ready, occupancy up to 2.
- Undefined: single register, states PS_EMPTY/PS_ONE only; in_ready = !out_valid | out_ready (combinational); occupancy ≤1; same flush, reset, counter behaviour.

## Structure
- Shared package pipe_pkg: state enum (PS_EMPTY, PS_ONE, PS_TWO), STALL_CNT_W=16 constant.
- One sub-module: pipe_sat_counter (width param, inc, synchronous active-low reset, saturate) used for stall_cnt.

## Test plan
- Reset: reset=0 two cycles with in_valid=1, in_data=32'hDEADBEEF → out_valid=0, out_data=0, stall_cnt=0, occupancy=0; after release in_ready=1.
- Stream: in_valid=1 data 1,2,3,4 consecutive, out_ready=1 → out_data 1,2,3,4 on cycles +1..+4, no gaps, occupancy=1.
- Back-pressure (skid on): out_ready=0, push 5,6 → occupancy=2, in_ready=0 next cycle; out_ready=1 → 5 then 6; stall_cnt equals held cycles.
- Flush: occupancy=2 holding 7,8, flush=1 with in_valid=1 data 9 → next cycle out_valid=0, out_data=0, 9 never emerges.
- Saturation: out_valid=1, out_ready=0 for 70000 cycles → stall_cnt=16'hFFFF, then flush leaves it at 16'hFFFF.
- Macro off: out_ready=0 holding 10 → in_ready=0 same cycle; out_ready=1 with in_valid=1 data 11 → 11 accepted same cycle, emitted next.
